// File: rtl/dds_ad9959_serial_driver.sv
// AD9959 serial-port driver: single-bit SD0 writes of CSR/FTW/CPOW/ACR for all four
// channels, then an I/O_UPDATE pulse; rewrites whenever the input words change.
module dds_ad9959_serial_driver #(
    parameter int CLK_DIV    = 4,
    parameter int RST_CYCLES = 16,
    parameter int INIT_WAIT  = 64,
    parameter int CS_GAP     = 4,
    parameter int UP_CYCLES  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_frq0,
    input  logic [31:0] i_frq1,
    input  logic [31:0] i_frq2,
    input  logic [31:0] i_frq3,
    input  logic [15:0] i_phase0,
    input  logic [15:0] i_phase1,
    input  logic [15:0] i_phase2,
    input  logic [15:0] i_phase3,
    input  logic [23:0] i_amp0,
    input  logic [23:0] i_amp1,
    input  logic [23:0] i_amp2,
    input  logic [23:0] i_amp3,
    output logic        o_sclk,
    output logic        o_cs,
    output logic        o_pwd,
    output logic        o_rst,
    output logic        o_up,
    output logic        o_sd0,
    output logic        o_sd1,
    output logic        o_sd2,
    output logic        o_sd3,
    output logic        o_p0,
    output logic        o_p1,
    output logic        o_p2,
    output logic        o_p3
);

    typedef enum logic [2:0] {
        S_RESET,
        S_RSTHOLD,
        S_INITWAIT,
        S_LOAD,
        S_FRAME,
        S_GAP,
        S_UPDATE,
        S_IDLE
    } state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] INIT_LAST = 16'(INIT_WAIT - 1);
    localparam logic [15:0] GAP_LAST  = 16'(CS_GAP - 1);
    localparam logic [15:0] UP_LAST   = 16'(UP_CYCLES - 1);

    state_t        r_state, w_stateN;
    logic [15:0]   r_cnt, w_cntN;
    logic [5:0]    r_bit, w_bitN;
    logic [3:0]    r_frame, w_frameN;
    logic          r_high, w_highN;
    logic          r_cs, w_csN;
    logic          r_sclk, w_sclkN;
    logic          r_sd0, w_sd0N;
    logic          r_rst, w_rstN;
    logic          r_up, w_upN;
    logic          w_load;
    logic [287:0]  w_live;
    logic [287:0]  r_snap;
    logic [3:0]    w_frameSel;
    logic [1:0]    w_ch;
    logic [31:0]   w_sFrq [4];
    logic [15:0]   w_sPhase [4];
    logic [23:0]   w_sAmp [4];
    logic [39:0]   w_word;
    logic [5:0]    w_len;
    logic [5:0]    w_nextBit;

    assign w_live = {i_amp3, i_amp2, i_amp1, i_amp0,
                     i_phase3, i_phase2, i_phase1, i_phase0,
                     i_frq3, i_frq2, i_frq1, i_frq0};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_sFrq[i]   = r_snap[i*32 +: 32];
            w_sPhase[i] = r_snap[128 + i*16 +: 16];
            w_sAmp[i]   = r_snap[192 + i*24 +: 24];
        end
    end

    // Frame words are left-aligned in 40 bits so bit 39 is always the first bit sent.
    always_comb begin
        case (r_state)
            S_GAP:   w_frameSel = r_frame + 4'd1;
            S_LOAD:  w_frameSel = 4'd0;
            default: w_frameSel = r_frame;
        endcase
        w_ch = w_frameSel[3:2];
        case (w_frameSel[1:0])
            2'd1: begin
                w_word = {8'h04, w_sFrq[w_ch]};
                w_len  = 6'd40;
            end
            2'd2: begin
                w_word = {8'h05, w_sPhase[w_ch], 16'h0000};
                w_len  = 6'd24;
            end
            2'd3: begin
                w_word = {8'h06, w_sAmp[w_ch], 8'h00};
                w_len  = 6'd32;
            end
            default: begin
                w_word = {8'h00, 8'(8'h10 << w_ch), 24'h000000};
                w_len  = 6'd16;
            end
        endcase
        w_nextBit = r_bit + 6'd1;
    end

    always_comb begin
        w_stateN = r_state;
        w_cntN   = r_cnt;
        w_bitN   = r_bit;
        w_frameN = r_frame;
        w_highN  = r_high;
        w_csN    = 1'b1;
        w_sclkN  = 1'b0;
        w_sd0N   = 1'b0;
        w_rstN   = 1'b0;
        w_upN    = 1'b0;
        w_load   = 1'b0;
        case (r_state)
            S_RESET: begin
                w_stateN = S_RSTHOLD;
                w_cntN   = '0;
                w_rstN   = 1'b1;
            end
            S_RSTHOLD: begin
                w_rstN = 1'b1;
                if (r_cnt == RST_LAST) begin
                    w_stateN = S_INITWAIT;
                    w_cntN   = '0;
                    w_rstN   = 1'b0;
                end else begin
                    w_cntN = r_cnt + 16'd1;
                end
            end
            S_INITWAIT: begin
                if (r_cnt == INIT_LAST) begin
                    w_stateN = S_LOAD;
                    w_cntN   = '0;
                end else begin
                    w_cntN = r_cnt + 16'd1;
                end
            end
            S_LOAD: begin
                w_load   = 1'b1;
                w_stateN = S_FRAME;
                w_frameN = '0;
                w_bitN   = '0;
                w_highN  = 1'b0;
                w_cntN   = '0;
                w_csN    = 1'b0;
                w_sd0N   = w_word[39];
            end
            S_FRAME: begin
                w_csN   = 1'b0;
                w_sclkN = r_sclk;
                w_sd0N  = r_sd0;
                // r_bit == w_len marks the single SCLK-low clock before CS releases.
                if (r_bit == w_len) begin
                    w_stateN = S_GAP;
                    w_cntN   = '0;
                    w_csN    = 1'b1;
                    w_sclkN  = 1'b0;
                    w_sd0N   = 1'b0;
                end else if (r_cnt != DIV_LAST) begin
                    w_cntN = r_cnt + 16'd1;
                end else begin
                    w_cntN = '0;
                    if (!r_high) begin
                        w_highN = 1'b1;
                        w_sclkN = 1'b1;
                    end else begin
                        w_highN = 1'b0;
                        w_sclkN = 1'b0;
                        w_bitN  = w_nextBit;
                        if (w_nextBit != w_len) begin
                            w_sd0N = w_word[6'd39 - w_nextBit];
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_cntN = '0;
                    if (r_frame == 4'd15) begin
                        w_stateN = S_UPDATE;
                        w_upN    = 1'b1;
                    end else begin
                        w_stateN = S_FRAME;
                        w_frameN = w_frameSel;
                        w_bitN   = '0;
                        w_highN  = 1'b0;
                        w_csN    = 1'b0;
                        w_sd0N   = w_word[39];
                    end
                end else begin
                    w_cntN = r_cnt + 16'd1;
                end
            end
            S_UPDATE: begin
                w_upN = 1'b1;
                if (r_cnt == UP_LAST) begin
                    w_stateN = S_IDLE;
                    w_upN    = 1'b0;
                    w_cntN   = '0;
                end else begin
                    w_cntN = r_cnt + 16'd1;
                end
            end
            S_IDLE: begin
                if (w_live != r_snap) begin
                    w_stateN = S_LOAD;
                end
            end
            default: w_stateN = S_RESET;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_RESET;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_frame <= '0;
            r_high  <= 1'b0;
            r_cs    <= 1'b1;
            r_sclk  <= 1'b0;
            r_sd0   <= 1'b0;
            r_rst   <= 1'b1;
            r_up    <= 1'b0;
            r_snap  <= '0;
        end else begin
            r_state <= w_stateN;
            r_cnt   <= w_cntN;
            r_bit   <= w_bitN;
            r_frame <= w_frameN;
            r_high  <= w_highN;
            r_cs    <= w_csN;
            r_sclk  <= w_sclkN;
            r_sd0   <= w_sd0N;
            r_rst   <= w_rstN;
            r_up    <= w_upN;
            if (w_load) begin
                r_snap <= w_live;
            end
        end
    end

    assign o_sclk = r_sclk;
    assign o_cs   = r_cs;
    assign o_sd0  = r_sd0;
    assign o_rst  = r_rst;
    assign o_up   = r_up;
    assign o_pwd  = 1'b0;
    assign o_sd1  = 1'b0;
    assign o_sd2  = 1'b0;
    assign o_sd3  = 1'b0;
    assign o_p0   = 1'b0;
    assign o_p1   = 1'b0;
    assign o_p2   = 1'b0;
    assign o_p3   = 1'b0;

endmodule

// File: tb/tb_dds_ad9959_serial_driver.sv
// Bench for dds_ad9959_serial_driver: decodes SD0 frames framed by CS and compares them
// with frame lists built from the input words, plus reset/update timing checks.
module tb_dds_ad9959_serial_driver;

    localparam int CLK_DIV    = 4;
    localparam int RST_CYCLES = 16;
    localparam int INIT_WAIT  = 64;
    localparam int UP_CYCLES  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] frq [4];
    logic [15:0] phase [4];
    logic [23:0] amp [4];
    logic sclk, cs, pwd, rstOut, up, sd0, sd1, sd2, sd3, p0, p1, p2, p3;

    int nCompared = 0;
    int nFailed   = 0;

    logic [39:0]  expWord [$];
    int           expLen [$];
    logic [39:0]  recvWord [$];
    logic [287:0] modelSnap = '0;
    bit           modelSnapValid = 1'b0;
    bit           upExpected = 1'b0;
    int           upCount = 0;
    int           upRun = 0;
    int           highRun = 0;
    int           lowRun = 0;
    bit           inFrame = 1'b0;
    int           bitCount = 0;
    logic [39:0]  shiftReg = '0;
    logic         prevCs = 1'b1;
    logic         prevSclk = 1'b0;
    logic         prevUp = 1'b0;
    logic         rstAtEdge = 1'b0;
    int           rstHighCnt = 0;
    bit           rstDone = 1'b0;
    int           sinceRstFall = 0;
    bit           firstFrame = 1'b1;
    logic [39:0]  popWord;
    int           popLen;

    dds_ad9959_serial_driver dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_frq0(frq[0]), .i_frq1(frq[1]), .i_frq2(frq[2]), .i_frq3(frq[3]),
        .i_phase0(phase[0]), .i_phase1(phase[1]), .i_phase2(phase[2]), .i_phase3(phase[3]),
        .i_amp0(amp[0]), .i_amp1(amp[1]), .i_amp2(amp[2]), .i_amp3(amp[3]),
        .o_sclk(sclk), .o_cs(cs), .o_pwd(pwd), .o_rst(rstOut), .o_up(up), .o_sd0(sd0),
        .o_sd1(sd1), .o_sd2(sd2), .o_sd3(sd3),
        .o_p0(p0), .o_p1(p1), .o_p2(p2), .o_p3(p3)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [287:0] liveVec();
        return {amp[3], amp[2], amp[1], amp[0], phase[3], phase[2], phase[1], phase[0],
                frq[3], frq[2], frq[1], frq[0]};
    endfunction

    function automatic logic [39:0] recvAt(input int idx);
        if (idx < recvWord.size()) return recvWord[idx];
        return 40'hFF_FFFF_FFFF;
    endfunction

    // A write sequence is 16 frames, right-aligned {instruction, data}, per channel CSR/FTW/CPOW/ACR.
    task automatic buildExpected();
        for (int ch = 0; ch < 4; ch++) begin
            expWord.push_back(40'(16'h0010 << ch));        expLen.push_back(16);
            expWord.push_back({8'h04, frq[ch]});             expLen.push_back(40);
            expWord.push_back({16'h0000, 8'h05, phase[ch]}); expLen.push_back(24);
            expWord.push_back({8'h00, 8'h06, amp[ch]});      expLen.push_back(32);
        end
    endtask

    always @(posedge clk) rstAtEdge <= rst_n;

    always @(negedge clk) begin
        checkOutput("const_pins", {pwd, sd1, sd2, sd3, p0, p1, p2, p3}, 64'd0);
        if (!rstAtEdge) begin
            checkOutput("reset_outputs", {cs, sclk, sd0, up, rstOut}, 64'b10001);
            expWord.delete();
            expLen.delete();
            inFrame = 1'b0;
            modelSnapValid = 1'b0;
            upExpected = 1'b0;
            upRun = 0;
            highRun = 0;
            lowRun = 0;
            rstHighCnt = 0;
            rstDone = 1'b0;
            firstFrame = 1'b1;
        end else begin
            if (!rstDone) begin
                if (rstOut) begin
                    rstHighCnt++;
                end else begin
                    rstDone = 1'b1;
                    checkOutput("rst_hold_len", rstHighCnt, RST_CYCLES);
                    sinceRstFall = 0;
                end
            end else begin
                sinceRstFall++;
                checkOutput("rst_low", rstOut, 0);
            end
            if (cs) checkOutput("cs_high_quiet", {sclk, sd0}, 0);

            if (prevCs && !cs) begin
                if (expWord.size() == 0) begin
                    checkOutput("up_before_rewrite", upExpected, 0);
                    if (modelSnapValid) checkOutput("rewrite_needed", liveVec() != modelSnap, 1);
                    if (firstFrame) begin
                        checkOutput("init_wait_ok", sinceRstFall >= INIT_WAIT, 1);
                        firstFrame = 1'b0;
                    end
                    buildExpected();
                    modelSnap = liveVec();
                    modelSnapValid = 1'b1;
                end
                inFrame = 1'b1;
                bitCount = 0;
                shiftReg = '0;
                lowRun = 0;
            end
            if (!prevSclk && sclk) begin
                checkOutput("sclk_low_len", lowRun, CLK_DIV);
                lowRun = 0;
                highRun = 0;
                shiftReg = {shiftReg[38:0], sd0};
                bitCount++;
            end
            if (prevSclk && !sclk) begin
                checkOutput("sclk_high_len", highRun, CLK_DIV);
                lowRun = 0;
            end
            if (!prevCs && cs && inFrame) begin
                checkOutput("frame_expected", expWord.size() > 0, 1);
                if (expWord.size() > 0) begin
                    popWord = expWord.pop_front();
                    popLen  = expLen.pop_front();
                    checkOutput("frame_len", bitCount, popLen);
                    checkOutput("frame_data", shiftReg, popWord);
                    if (expWord.size() == 0) upExpected = 1'b1;
                end
                recvWord.push_back(shiftReg);
                inFrame = 1'b0;
            end
            if (!cs && !sclk) lowRun++;
            if (sclk) highRun++;

            if (up) begin
                upRun++;
                checkOutput("up_cs_high", cs, 1);
            end
            if (!prevUp && up) checkOutput("up_allowed", upExpected, 1);
            if (prevUp && !up) begin
                checkOutput("up_width", upRun, UP_CYCLES);
                upRun = 0;
                upExpected = 1'b0;
                upCount++;
            end
        end
        prevCs = cs;
        prevSclk = sclk;
        prevUp = up;
    end

    task automatic applyStimulus(input int ch, input logic [31:0] newFrq);
        frq[ch] = newFrq;
    endtask

    task automatic waitUp(input int target, input int budget, input string name);
        int n = 0;
        while (upCount < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput(name, upCount >= target, 1);
        @(posedge clk);
        #2;
    endtask

    task automatic waitRecv(input int target, input int budget, input string name);
        int n = 0;
        while (recvWord.size() < target && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput(name, recvWord.size() >= target, 1);
        n = 0;
        while (cs && n < 50) begin
            @(posedge clk);
            #2;
            n++;
        end
    endtask

    initial begin
        int idleCount;
        frq[0] = 32'd33;  frq[1] = 32'd98;  frq[2] = 32'd164; frq[3] = 32'd164;
        phase[0] = 16'd0; phase[1] = 16'd0; phase[2] = 16'd0; phase[3] = 16'd8192;
        for (int i = 0; i < 4; i++) amp[i] = 24'd0;

        repeat (5) @(posedge clk);
        #2;
        checkOutput("rst_cs", cs, 1);
        checkOutput("rst_rst", rstOut, 1);
        checkOutput("rst_up", up, 0);
        rst_n = 1'b1;

        waitUp(1, 8000, "seq1_done");
        checkOutput("seq1_count", recvWord.size(), 16);
        checkOutput("seq1_f0", recvAt(0), 40'h00_0010);
        checkOutput("seq1_f1", recvAt(1), 40'h04_00000021);
        checkOutput("seq1_f2", recvAt(2), 40'h05_0000);
        checkOutput("seq1_f3", recvAt(3), 40'h06_000000);
        checkOutput("seq1_f4", recvAt(4), 40'h00_0020);
        checkOutput("seq1_f5", recvAt(5), 40'h04_00000062);
        checkOutput("seq1_f12", recvAt(12), 40'h00_0080);
        checkOutput("seq1_f13", recvAt(13), 40'h04_000000A4);
        checkOutput("seq1_f14", recvAt(14), 40'h05_2000);
        checkOutput("seq1_f15", recvAt(15), 40'h06_000000);

        idleCount = recvWord.size();
        repeat (1000) @(posedge clk);
        #2;
        checkOutput("idle_no_frames", recvWord.size(), idleCount);
        checkOutput("idle_up_count", upCount, 1);
        checkOutput("idle_pins", {cs, sclk}, 2'b10);

        applyStimulus(0, 32'd98);
        applyStimulus(1, 32'd98);
        waitUp(2, 8000, "seq2_done");
        checkOutput("seq2_count", recvWord.size(), 32);
        checkOutput("seq2_f1", recvAt(17), 40'h04_00000062);
        checkOutput("seq2_f5", recvAt(21), 40'h04_00000062);

        applyStimulus(3, 32'h12345678);
        waitRecv(37, 8000, "seq3_reach_f5");
        repeat (10) @(posedge clk);
        #2;
        applyStimulus(2, 32'h0BADF00D);
        waitUp(4, 16000, "seq4_done");
        checkOutput("seq34_count", recvWord.size(), 64);
        checkOutput("seq3_f9_old", recvAt(41), 40'h04_000000A4);
        checkOutput("seq3_f13", recvAt(45), 40'h04_12345678);
        checkOutput("seq4_f9_new", recvAt(57), 40'h04_0BADF00D);

        applyStimulus(0, 32'h00000001);
        waitRecv(65, 8000, "seq5_reach_ftw");
        repeat (20) @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        checkOutput("midrst_pins", {cs, sclk, rstOut, up}, 4'b1010);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        waitUp(5, 8000, "seq6_done");
        checkOutput("seq6_count", recvWord.size(), 81);
        checkOutput("seq6_f1", recvAt(66), 40'h04_00000001);
        checkOutput("seq6_f9", recvAt(74), 40'h04_0BADF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed + 1);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
